uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal 1 or 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_bd_en  input  1  one-cycle baud tick, one pulse per bit period.
REQ-006 SHALL have port req0_valid  input  1  requester 0 has a byte to send.
REQ-007 SHALL have port req0_data  input  DATA_BITS  requester 0 byte, LSB sent first.
REQ-008 SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle when valid.
REQ-009 SHALL have ports req1_valid, req1_data, req1_ready, identical to the requester 0 ports, for requester 1.
REQ-010 SHALL have port tx  output  1  serial line; idle high.
REQ-011 SHALL have port busy  output  1  high whenever a frame is in progress.
REQ-012 SHALL have port grant_id  output  1  requester currently or most recently served.

Function
REQ-013 SHALL implement states IDLE, ALIGN, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-014 SHALL assert reqN_ready only in IDLE and only for the requester selected by arbitration; at most one ready high per cycle.
REQ-015 SHALL arbitrate round-robin: only one valid -> grant it; both valid -> grant the one not equal to last_grant; last_grant resets to 1, so requester 0 wins the first tie.
REQ-016 SHALL, on accept (valid && ready), latch data into the shift register, set grant_id and last_grant to the winner, and enter ALIGN; tx remains 1.
REQ-017 SHALL ignore a tx_bd_en coinciding with the accept cycle; ALIGN waits for the next tick.
REQ-018 SHALL, in ALIGN, on tx_bd_en: drive tx=0 and enter START.
REQ-019 SHALL, in START, on tx_bd_en: drive tx=data[0], clear bit_cnt, and enter DATA.
REQ-020 SHALL, in DATA, on tx_bd_en: if bit_cnt == DATA_BITS-1, go to PARITY (or STOP, with tx=1, when parity is disabled); else shift, drive the next bit, and increment bit_cnt.
REQ-021 SHALL, in PARITY, on tx_bd_en: drive tx=1 and enter STOP.
REQ-022 SHALL, in STOP, on tx_bd_en: if stop_cnt == STOP_BITS-1, return to IDLE; else increment stop_cnt; tx remains 1.
REQ-023 SHALL hold all state and tx when tx_bd_en is low; each line bit lasts exactly one tick-to-tick period.
REQ-024 SHALL allow a new accept in the first IDLE cycle after the STOP exit (back-to-back frames).
REQ-025 SHALL leave reqN_valid/data unsampled while busy; a requester holding valid keeps its byte until ready.

Reset
REQ-026 SHALL, when rst is sampled low (including mid-frame), set next cycle: state=IDLE, tx=1, busy=0, req0_ready/req1_ready follow IDLE arbitration, grant_id=0, last_grant=1, bit_cnt=0, stop_cnt=0, shift register=0.
REQ-027 SHALL drop an interrupted frame silently; it is not retransmitted.

Configuration
REQ-028 SHALL use macro UART_TX_PARITY_EN: when defined, the PARITY state drives even parity (XOR of latched data bits) for one bit period between the last data bit and STOP; when undefined, PARITY is unreachable and DATA goes directly to STOP.

Verification (tx_bd_en pulsed every 4 clk unless stated)
REQ-029 SHALL cover: req0 sends 8'hA5, parity off -> tx = 0,1,0,1,0,0,1,0,1,1 per bit period, busy high 10 periods plus ALIGN wait, req0_ready high exactly 1 cycle.
REQ-030 SHALL cover: UART_TX_PARITY_EN defined, req1 sends 8'h07 -> parity bit 1 after data, frame 11 bits, grant_id=1.
REQ-031 SHALL cover: both valid continuously from reset with bytes 8'h11/8'h22 -> frames alternate 11,22,11,22; req0 served first.
REQ-032 SHALL cover: rst low during DATA bit 3 -> next cycle tx=1, busy=0, grant_id=0; next frame starts with a full start bit.
REQ-033 SHALL cover: tx_bd_en high on the accept cycle -> start bit begins on the following tick, not that one.
REQ-034 SHALL cover: STOP_BITS=2, tick every 868 clk (115200 baud @100 MHz) -> tx stays high 2x868 clk after the last data bit before the next start bit.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter, paced by an external one-cycle baud tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and STOP.
module uart_tx_sched #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_bd_en,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  // state  | meaning
  // IDLE   | line high, arbitrating and accepting a byte
  // ALIGN  | byte latched, waiting for the first tick to open the start bit
  // START  | start bit (0) on the line
  // DATA   | data bits on the line, LSB first
  // PARITY | even parity bit on the line (parity builds only)
  // STOP   | stop bit(s) on the line
  typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 last_grant;
  logic                 winner;
  logic [DATA_BITS-1:0] sel_data;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // On a tie, serve whichever requester was not granted last time
  assign winner     = req1_valid & (~req0_valid | ~last_grant);
  assign sel_data   = winner ? req1_data : req0_data;
  assign req0_ready = (state == IDLE) & req0_valid & ~winner;
  assign req1_ready = (state == IDLE) & winner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          // A tick in the accept cycle is deliberately ignored; ALIGN waits for the next one
          if (req0_valid | req1_valid) begin
            shift_reg  <= sel_data;
            grant_id   <= winner;
            last_grant <= winner;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^sel_data;
`endif
            state      <= ALIGN;
          end
        end
        ALIGN: begin
          if (tx_bd_en) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tx_bd_en) begin
            tx      <= shift_reg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tx_bd_en) begin
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx       <= parity_bit;
              state    <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tx_bd_en) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tx_bd_en) begin
            if (stop_cnt == 1'(STOP_BITS - 1))
              state <= IDLE;
            else
              stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default instance plus a STOP_BITS=2 instance on shared inputs.
// Honours UART_TX_PARITY_EN when the bundle is built with it.
module tb_uart_tx_sched;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_bd_en = 1'b0;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, tx, busy, grant_id;
  logic       req0_ready_b, req1_ready_b, tx_b, busy_b, grant_id_b;

  int tick_per = 4;
  int tick_cnt = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_sched u_dut (
    .clk(clk), .rst(rst), .tx_bd_en(tx_bd_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(2)) u_dut_2stop (
    .clk(clk), .rst(rst), .tx_bd_en(tx_bd_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready_b),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready_b),
    .tx(tx_b), .busy(busy_b), .grant_id(grant_id_b)
  );

  always #5 clk = ~clk;

  // Baud tick generator, one pulse every tick_per clocks, driven on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tick_cnt >= tick_per - 1) begin
      tick_cnt = 0;
      tx_bd_en = 1'b1;
    end else begin
      tick_cnt++;
      tx_bd_en = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic send(input bit who, input logic [7:0] d);
    int  n = 0;
    bit  seen = 1'b0;
    if (who) begin req1_data = d; req1_valid = 1'b1; end
    else     begin req0_data = d; req0_valid = 1'b1; end
    #1;
    while (!seen && n < BUDGET) begin
      if (who ? req1_ready : req0_ready) seen = 1'b1;
      else begin step(); n++; end
    end
    check("ready_seen", seen, 1);
    step();
    check("ready_one_cycle", who ? req1_ready : req0_ready, 0);
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Mid-bit sampling receiver on the default instance; returns cycle stamp of start detection
  task automatic rx_frame(input string tag, input logic [7:0] exp, output int t0);
    int n = 0;
    logic [7:0] d;
    t0 = cyc;
    while (tx !== 1'b0 && n < BUDGET) begin step(); n++; end
    check({tag, "_start_seen"}, n < BUDGET, 1);
    if (n < BUDGET) begin
      t0 = cyc;
      repeat (tick_per / 2) step();
      check({tag, "_start_bit"}, tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (tick_per) step();
        d[i] = tx;
      end
      check({tag, "_data"}, d, exp);
`ifdef UART_TX_PARITY_EN
      repeat (tick_per) step();
      check({tag, "_parity"}, tx, ^exp);
`endif
      repeat (tick_per) step();
      check({tag, "_stop_bit"}, tx, 1);
    end
  endtask

  task automatic wait_idle(output int t);
    int n = 0;
    while (busy && n < BUDGET) begin step(); n++; end
    check("idle_reached", n < BUDGET, 1);
    t = cyc;
  endtask

  initial begin
    int t0, t1, n, last_rise;
    logic prev;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    rst = 1'b0;
    repeat (3) step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ready0_novalid", req0_ready, 0);

    // Both requesters valid from reset: first tie goes to requester 0, then alternation
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("tie_ready0", req0_ready, 1);
    check("tie_ready1", req1_ready, 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rx_frame("rr", (k % 2 == 0) ? 8'h11 : 8'h22, t0);
      check("rr_grant_id", grant_id, k % 2);
    end

    // Single byte from requester 0, frame length from start edge to idle
    do_reset();
    send(1'b0, 8'hA5);
    rx_frame("a5", 8'hA5, t0);
    wait_idle(t1);
    check("a5_frame_len", t1 - t0, NB * 4);
    check("a5_grant_id", grant_id, 0);

    send(1'b1, 8'h07);
    rx_frame("x07", 8'h07, t0);
    check("x07_grant_id", grant_id, 1);
    wait_idle(t1);

    // Accept coinciding with a tick: start bit must wait a full period
    n = 0;
    while (tx_bd_en !== 1'b1 && n < 10) begin step(); n++; end
    check("tick_found", tx_bd_en, 1);
    req0_data = 8'h3C; req0_valid = 1'b1;
    #1;
    check("tick_accept_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    n = 0;
    while (tx === 1'b1 && n < 50) begin n++; step(); end
    check("align_wait", n, 4);
    wait_idle(t1);

    // Reset during data bit 3 drops the frame; the next one starts with a full start bit
    send(1'b1, 8'hF0);
    n = 0;
    while (tx !== 1'b0 && n < BUDGET) begin step(); n++; end
    repeat (2 + 4 * 4) step();
    check("pre_rst_grant_id", grant_id, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    step();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    rst = 1'b1;
    repeat (20) step();
    check("no_retransmit", busy, 0);
    send(1'b0, 8'h03);
    n = 0;
    while (tx !== 1'b0 && n < BUDGET) begin step(); n++; end
    n = 0;
    while (tx === 1'b0 && n < 50) begin n++; step(); end
    check("full_start_bit", n, 4);
    wait_idle(t1);

    // Two stop bits at 868 clocks per bit: line high 2*868 clocks after the last 0 bit
    tick_per = 868;
    do_reset();
    send(1'b0, 8'h55);
    prev = tx_b;
    last_rise = cyc;
    n = 0;
    while (busy_b && n < 4 * BUDGET) begin
      step();
      n++;
      if (tx_b && !prev) last_rise = cyc;
      prev = tx_b;
    end
    check("stop2_idle_reached", n < 4 * BUDGET, 1);
    check("stop2_high_len", cyc - last_rise, 2 * 868);
    check("stop2_tx_idle", tx_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
